// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states, default width and
// the iteration-counter width helper.
package div_pkg;

  localparam int unsigned DefaultW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } div_state_e;

  // Counter must hold 0..W, so it needs $clog2(W+1) bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Ripple-carry adder/subtractor; subtraction inverts b and injects carry-in of one.
module div_addsub #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic c;
    logic bb;
    sum  = '0;
    c    = sub;
    bb   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      bb     = b[i] ^ sub;
      sum[i] = a[i] ^ bb ^ c;
      c      = (a[i] & bb) | (c & (a[i] ^ bb));
    end
    cout = c;
  end

endmodule

// File: rtl/signed_div_seq.sv
// Iterative restoring signed divider: one quotient bit per clock, truncating quotient,
// remainder carrying the dividend's sign, fixed latency of W+1 cycles after start.
module signed_div_seq
  import div_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_width(W);

  div_state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic [W:0]      r_q;
  logic [W-1:0]    qmag_q;
  logic [W-1:0]    dmag_q;
  logic            sign_n_q, sign_d_q, zero_q;
  logic [W-1:0]    quo_q, rem_q;
  logic            done_q, dbz_q;

  logic [W:0]      trial;
  logic            trial_cout;
  logic            last_iter;
  logic [W-1:0]    quo_fix, rem_fix;
  logic            unused_bits;

  div_addsub #(
    .N (W + 1)
  ) u_addsub (
    .a    ({r_q[W-1:0], qmag_q[W-1]}),
    .b    ({1'b0, dmag_q}),
    .sub  (1'b1),
    .sum  (trial),
    .cout (trial_cout)
  );

  // R never exceeds |divisor| so its top bit and the carry-out carry no extra information.
  assign unused_bits = trial_cout ^ r_q[W];

  assign last_iter = (cnt_q == CntW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last_iter) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Divide-by-zero forces an all-ones quotient regardless of the dividend's sign.
  always_comb begin
    quo_fix = (sign_n_q ^ sign_d_q) ? -qmag_q : qmag_q;
    if (zero_q) quo_fix = '1;
    rem_fix = sign_n_q ? -r_q[W-1:0] : r_q[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      r_q      <= '0;
      qmag_q   <= '0;
      dmag_q   <= '0;
      sign_n_q <= 1'b0;
      sign_d_q <= 1'b0;
      zero_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StFix);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            qmag_q   <= dividend[W-1] ? -dividend : dividend;
            dmag_q   <= divisor[W-1] ? -divisor : divisor;
            sign_n_q <= dividend[W-1];
            sign_d_q <= divisor[W-1];
            zero_q   <= (divisor == '0);
            r_q      <= '0;
            cnt_q    <= '0;
          end
        end
        StCalc: begin
          if (!trial[W]) begin
            r_q    <= trial;
            qmag_q <= {qmag_q[W-2:0], 1'b1};
          end else begin
            r_q    <= {r_q[W-1:0], qmag_q[W-1]};
            qmag_q <= {qmag_q[W-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CntW'(1);
        end
        StFix: begin
          quo_q <= quo_fix;
          rem_q <= rem_fix;
          dbz_q <= zero_q;
        end
        default: ;
      endcase
    end
  end

  assign quo         = quo_q;
  assign rem         = rem_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_div_seq.sv
// Directed and randomized checks of signed_div_seq against a plain-arithmetic reference.
module tb_signed_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quo, rem;
  logic        busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  signed_div_seq #(
    .W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quo         (quo),
    .rem         (rem),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating signed division, computed in 32-bit ints then wrapped to 16 bits.
  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[15:0];
      r  = ri[15:0];
      z  = 1'b0;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input int lat);
    logic [15:0] eq, er;
    logic        ez;
    ref_div(a, b, eq, er, ez);
    chk({tag, " latency"}, lat, 17);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " quo"}, quo, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " dbz"}, div_by_zero, ez);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat;
    launch(a, b);
    chk({tag, " busy_calc"}, busy, 1'b1);
    wait_done(lat);
    check_result(tag, a, b, lat);
  endtask

  initial begin
    int          lat;
    int          dones;
    logic [15:0] a, b, hq, hr;
    logic        hz;

    repeat (3) step();
    chk("reset quo", quo, 16'h0);
    chk("reset rem", rem, 16'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    step();

    run_op("100/7", 16'd100, 16'd7);
    chk("100/7 quo const", quo, 16'h000E);
    // Each run_op starts in the previous done cycle, so these are back-to-back.
    run_op("-100/7", -16'sd100, 16'd7);
    chk("-100/7 quo const", quo, 16'hFFF2);
    chk("-100/7 rem const", rem, 16'hFFFE);
    run_op("100/-7", 16'd100, -16'sd7);
    chk("100/-7 rem const", rem, 16'h0002);
    run_op("min/-1", 16'h8000, 16'hFFFF);
    chk("min/-1 quo const", quo, 16'h8000);
    run_op("min/1", 16'h8000, 16'h0001);
    run_op("1234/0", 16'd1234, 16'd0);
    chk("1234/0 quo const", quo, 16'hFFFF);
    run_op("-5/0", -16'sd5, 16'd0);
    run_op("7/100", 16'd7, 16'd100);
    run_op("min/min", 16'h8000, 16'h8000);

    // Outputs hold between done pulses.
    ref_div(-16'sd5, 16'd0, hq, hr, hz);
    ref_div(16'h8000, 16'h8000, hq, hr, hz);
    repeat (5) step();
    chk("hold quo", quo, hq);
    chk("hold rem", rem, hr);
    chk("hold done low", done, 1'b0);

    // Reset in the middle of an operation.
    launch(16'd1000, 16'd3);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst quo", quo, 16'h0);
    chk("midrst rem", rem, 16'h0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      step();
    end
    chk("midrst no done", dones, 0);
    run_op("1000/3", 16'd1000, 16'd3);
    chk("1000/3 quo const", quo, 16'd333);
    chk("1000/3 rem const", rem, 16'd1);

    // Start while busy is ignored.
    step();
    launch(16'd5000, 16'd9);
    repeat (4) step();
    dividend = 16'd77;
    divisor  = 16'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
    check_result("ignored start", 16'd5000, 16'd9, lat + 5);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0: b = 16'h0;
        1: b = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'hFFFF;
        2: a = 16'h8000;
        3: b = 16'($urandom_range(0, 15)) - 16'd8;
        default: ;
      endcase
      run_op($sformatf("rnd%0d %0h/%0h", i, a, b), a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
